// File: rtl/val_matrix_loader_if.sv
// Element stream in, completed DIM x DIM matrix out, plus status (fill count, framing error).
// master: the loader (drives in_ready, out_valid, out_mat, fill_cnt, err).
// slave: the producer/consumer environment around the loader.
interface val_matrix_loader_if #(
  parameter int DIM = 3,
  parameter int DW  = 4
);
  localparam int IW = $clog2(DIM * DIM);

  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_mat [DIM][DIM];
  logic [IW:0]   fill_cnt;
  logic          err;

  modport master (
    input  abort, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_mat, fill_cnt, err
  );

  modport slave (
    output abort, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_mat, fill_cnt, err
  );
endinterface

// File: rtl/val_matrix_loader.sv
// Assembles DIM*DIM stream elements into a matrix (row-major; column-major with VAL_MATRIX_LOADER_TRANSPOSE_EN).
// Latency: last element accepted at cycle N -> out_valid at N+1; one bubble cycle between matrices.
// Backpressure: in_ready drops while a matrix is held; the held matrix stays until out_ready, abort flushes.
module val_matrix_loader #(
  parameter int DIM = 3,
  parameter int DW  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  val_matrix_loader_if.master  bus
);

  localparam int IW  = $clog2(DIM * DIM);
  localparam int NEL = DIM * DIM;
  localparam int RW  = (DIM > 1) ? $clog2(DIM) : 1;

  localparam logic [IW:0]   LAST_IDX = (IW + 1)'(NEL - 1);
  localparam logic [RW-1:0] DIM_M1   = RW'(DIM - 1);

  // Legacy-compatible state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] col_q, col_d;
  logic [RW-1:0] nxt_row, nxt_col;
  logic [IW:0]   fill_q, fill_d;
  logic          err_q, err_d;
  logic [DW-1:0] mat_q [DIM][DIM];

  logic accept;
  logic wr_en;
  logic flush;

  // Both handshake outputs are pure state decodes, so out_ready never reaches in_ready combinationally.
  assign accept = bus.in_valid && (state_q == ST_FILL);
  assign flush  = bus.abort && (state_q != ST_IDLE);
  // A beat that coincides with abort is dropped, not written.
  assign wr_en  = accept && !bus.abort;

  // Write-pointer advance: the fast index wraps at DIM-1 and carries into the slow index.
`ifdef VAL_MATRIX_LOADER_TRANSPOSE_EN
  always_comb begin
    nxt_row = row_q;
    nxt_col = col_q;
    if (row_q == DIM_M1) begin
      nxt_row = '0;
      nxt_col = col_q + 1'b1;
    end else begin
      nxt_row = row_q + 1'b1;
    end
  end
`else
  always_comb begin
    nxt_row = row_q;
    nxt_col = col_q;
    if (col_q == DIM_M1) begin
      nxt_col = '0;
      nxt_row = row_q + 1'b1;
    end else begin
      nxt_col = col_q + 1'b1;
    end
  end
`endif

  // Next-state: framing, error pulse and handshake; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    fill_d  = fill_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FILL;
      end
      ST_FILL: begin
        if (accept) begin
          row_d  = nxt_row;
          col_d  = nxt_col;
          fill_d = fill_q + 1'b1;
          if (fill_q == LAST_IDX) begin
            // Full matrix: emit it even when in_last is missing, but flag the framing slip.
            state_d = ST_HOLD;
            row_d   = '0;
            col_d   = '0;
            fill_d  = '0;
            err_d   = !bus.in_last;
          end else if (bus.in_last) begin
            // Early last: discard the partial frame; stale elements get overwritten later.
            row_d  = '0;
            col_d  = '0;
            fill_d = '0;
            err_d  = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
        row_d   = '0;
        col_d   = '0;
        fill_d  = '0;
      end
    endcase
    if (flush) begin
      state_d = ST_FILL;
      row_d   = '0;
      col_d   = '0;
      fill_d  = '0;
      err_d   = 1'b0;
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

  // Matrix storage: one element written per accepted beat, never cleared except by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          mat_q[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      mat_q[row_q][col_q] <= bus.in_data;
    end
  end

  assign bus.in_ready  = (state_q == ST_FILL);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.fill_cnt  = fill_q;
  assign bus.err       = err_q;

  for (genvar gr = 0; gr < DIM; gr++) begin : g_row
    for (genvar gc = 0; gc < DIM; gc++) begin : g_col
      assign bus.out_mat[gr][gc] = mat_q[gr][gc];
    end
  end

  // The fill counter wraps before it can reach DIM*DIM.
  a_fill_bound: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_FILL) |-> (fill_q <= LAST_IDX));

  // Input and output sides are never open at the same time.
  a_hs_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(bus.in_ready && bus.out_valid));

endmodule

// File: tb/tb_val_matrix_loader.sv
// Directed, table-driven check of val_matrix_loader at DIM=3, DW=4.
// Inputs are driven on the falling edge, outputs sampled on the following falling edge.
// Expected matrices are derived from the beat sequence and the fill order.
module tb_val_matrix_loader;

  logic clk;
  logic rst;

  val_matrix_loader_if #(.DIM(3), .DW(4)) bus ();

  val_matrix_loader #(.DIM(3), .DW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       l;
    logic       ordy;
    logic       ab;
    logic       e_ir;
    logic       e_ov;
    int         e_fc;
    logic       e_err;
    logic       cm;
  } vec_t;

  vec_t       vq[$];
  logic [3:0] exp_mat [3][3];
  int         total;
  int         bad;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_mat(input string nm);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("%s.mat[%0d][%0d]", nm, r, c), int'(bus.out_mat[r][c]), int'(exp_mat[r][c]));
      end
    end
  endtask

  // Expected matrix for a frame whose beat k carries (start + dir*k) mod 16.
  task automatic set_exp(input int start, input int dir);
    int val;
    for (int k = 0; k < 9; k++) begin
      val = (start + dir * k) & 15;
`ifdef VAL_MATRIX_LOADER_TRANSPOSE_EN
      exp_mat[k % 3][k / 3] = 4'(val);
`else
      exp_mat[k / 3][k % 3] = 4'(val);
`endif
    end
  endtask

  task automatic add(input logic v, input int d, input logic l, input logic ordy, input logic ab,
                     input logic e_ir, input logic e_ov, input int e_fc, input logic e_err,
                     input logic cm);
    vec_t t;
    t.v = v; t.d = 4'(d); t.l = l; t.ordy = ordy; t.ab = ab;
    t.e_ir = e_ir; t.e_ov = e_ov; t.e_fc = e_fc; t.e_err = e_err; t.cm = cm;
    vq.push_back(t);
  endtask

  // n ordinary (non-last) beats starting from fill count fc0.
  task automatic add_fill_beats(input int start, input int dir, input int n, input int fc0);
    for (int k = 0; k < n; k++) begin
      add(1'b1, (start + dir * k) & 15, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, fc0 + k + 1, 1'b0, 1'b0);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    bus.abort     = 1'b0;
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      bus.in_valid  = vq[i].v;
      bus.in_data   = vq[i].d;
      bus.in_last   = vq[i].l;
      bus.out_ready = vq[i].ordy;
      bus.abort     = vq[i].ab;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s[%0d].in_ready", tag, i), int'(bus.in_ready), int'(vq[i].e_ir));
      chk($sformatf("%s[%0d].out_valid", tag, i), int'(bus.out_valid), int'(vq[i].e_ov));
      chk($sformatf("%s[%0d].fill_cnt", tag, i), int'(bus.fill_cnt), vq[i].e_fc);
      chk($sformatf("%s[%0d].err", tag, i), int'(bus.err), int'(vq[i].e_err));
      if (vq[i].cm) chk_mat($sformatf("%s[%0d]", tag, i));
    end
    vq.delete();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    idle_inputs();
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) exp_mat[r][c] = 4'd0;

    // Reset values.
    #1 rst = 1'b1;
    #1;
    chk("rst.in_ready", int'(bus.in_ready), 0);
    chk("rst.out_valid", int'(bus.out_valid), 0);
    chk("rst.fill_cnt", int'(bus.fill_cnt), 0);
    chk("rst.err", int'(bus.err), 0);
    chk_mat("rst");
    #10 rst = 1'b0;
    @(negedge clk);
    chk("idle_to_fill.in_ready", int'(bus.in_ready), 1);

    // 1: clean frame 0..8, consumer always ready; out_valid for exactly one cycle.
    set_exp(0, 1);
    add_fill_beats(0, 1, 8, 0);
    add(1, 8, 1, 1, 0,  0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0,  1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0,  1, 0, 0, 0, 0);
    run_vecs("t1");

    // 2: consumer stalls 5 cycles; extra in_valid while held is ignored.
    set_exp(3, 1);
    add_fill_beats(3, 1, 8, 0);
    add(1, 11, 1, 0, 0,  0, 1, 0, 0, 1);
    for (int k = 0; k < 5; k++) add(1, 15, 0, 0, 0,  0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0,  1, 0, 0, 0, 1);
    run_vecs("t2");

    // 3: early last on beat 4, then a clean descending frame A..2.
    add_fill_beats(1, 1, 3, 0);
    add(1, 4, 1, 1, 0,  1, 0, 0, 1, 0);
    set_exp(10, -1);
    add_fill_beats(10, -1, 8, 0);
    add(1, 2, 1, 1, 0,  0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0,  1, 0, 0, 0, 1);
    run_vecs("t3");

    // 4: nine beats with no in_last: emitted, err alongside out_valid.
    set_exp(5, 1);
    add_fill_beats(5, 1, 8, 0);
    add(1, 13, 0, 1, 0,  0, 1, 0, 1, 1);
    add(0, 0, 0, 1, 0,  1, 0, 0, 0, 1);
    run_vecs("t4");

    // 5: abort on the final accept, then a full frame, then abort beating out_ready in HOLD.
    add_fill_beats(0, 1, 8, 0);
    add(1, 8, 1, 1, 1,  1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0,  1, 0, 0, 0, 0);
    run_vecs("t5a");
    set_exp(7, 1);
    add_fill_beats(7, 1, 8, 0);
    add(1, 15, 1, 0, 0,  0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 1,  1, 0, 0, 0, 1);
    run_vecs("t5b");

    // 6: asynchronous reset mid-frame.
    add_fill_beats(0, 1, 5, 0);
    run_vecs("t6");
    idle_inputs();
    #1 rst = 1'b1;
    #1;
    chk("t6.rst.in_ready", int'(bus.in_ready), 0);
    chk("t6.rst.out_valid", int'(bus.out_valid), 0);
    chk("t6.rst.fill_cnt", int'(bus.fill_cnt), 0);
    chk("t6.rst.err", int'(bus.err), 0);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) exp_mat[r][c] = 4'd0;
    chk_mat("t6.rst");
    #1 rst = 1'b0;
    #1;
    chk("t6.release.in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t6.second_edge.in_ready", int'(bus.in_ready), 1);
    chk("t6.second_edge.fill_cnt", int'(bus.fill_cnt), 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
